// File: rtl/fetch_pc_stage.sv
// Fetch stage front end: owns the program counter and the IF/ID pipeline latch,
// and keeps a saturating count of stall cycles for debug.
module fetch_pc_stage #(
  parameter int unsigned         ADDR_W    = 64,
  parameter int unsigned         INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]  NOP_INSTR = 32'hD503201F,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               flush,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic               ifid_valid,
  output logic [CNT_W-1:0]   stall_count
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_seq;
  logic              cnt_sat;

  assign pc_seq    = pc + ADDR_W'(4);
  assign cnt_sat   = &stall_count;
  assign imem_addr = pc;

  // Redirect beats stall so the wrong-path fetch is discarded even while the
  // hazard unit is holding; stall beats flush so a held instruction survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ifid_pc     <= '0;
      ifid_instr  <= NOP_INSTR;
      ifid_valid  <= 1'b0;
      stall_count <= '0;
    end else if (redirect) begin
      pc          <= redirect_pc;
      ifid_pc     <= '0;
      ifid_instr  <= NOP_INSTR;
      ifid_valid  <= 1'b0;
    end else if (stall) begin
      if (!cnt_sat) begin
        stall_count <= stall_count + CNT_W'(1);
      end
    end else if (flush) begin
      pc          <= pc_seq;
      ifid_pc     <= '0;
      ifid_instr  <= NOP_INSTR;
      ifid_valid  <= 1'b0;
    end else begin
      pc          <= pc_seq;
      ifid_pc     <= pc;
      ifid_instr  <= imem_instr;
      ifid_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Bench for fetch_pc_stage: directed scenarios with literal expectations, then
// random control traffic checked every cycle against a behavioural model.
module tb_fetch_pc_stage;

  localparam logic [31:0] NOP   = 32'hD503201F;
  localparam int          CMAX  = 15;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, flush;
  logic [63:0] redirect_pc;
  logic [31:0] imem_instr;
  logic [63:0] imem_addr, ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [3:0]  stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_pc_stage #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush(flush), .imem_instr(imem_instr),
    .imem_addr(imem_addr), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory: a few fixed words, a hash elsewhere.
  function automatic logic [31:0] mem_fn(input logic [63:0] a);
    if (a == 64'd0) return 32'h11111111;
    if (a == 64'd4) return 32'h22222222;
    if (a == 64'd8) return 32'h33333333;
    return a[31:0] ^ a[63:32] ^ 32'hA5A50000;
  endfunction

  assign imem_instr = mem_fn(imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must hold after each edge.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_instr;
  logic        m_v;
  int          m_cnt;
  bit          m_init = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 64'd0; m_ipc = 64'd0; m_instr = NOP; m_v = 1'b0; m_cnt = 0; m_init = 1;
    end else if (stall && !redirect) begin
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    end else begin
      if (redirect || flush) begin
        m_ipc = 64'd0; m_instr = NOP; m_v = 1'b0;
      end else begin
        m_ipc = m_pc; m_instr = mem_fn(m_pc); m_v = 1'b1;
      end
      m_pc = redirect ? redirect_pc : m_pc + 64'd4;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("model_imem_addr", imem_addr, m_pc);
      chk("model_ifid_pc", ifid_pc, m_ipc);
      chk("model_ifid_instr", {32'd0, ifid_instr}, {32'd0, m_instr});
      chk("model_ifid_valid", {63'd0, ifid_valid}, {63'd0, m_v});
      chk("model_stall_count", {60'd0, stall_count}, 64'(m_cnt));
    end
  end

  task automatic cyc(input logic r, input logic s, input logic rd,
                     input logic [63:0] rp, input logic f);
    reset = r; stall = s; redirect = rd; redirect_pc = rp; flush = f;
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 64'd0, 0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_valid", {63'd0, ifid_valid}, 64'd0);
    chk("rst_instr", {32'd0, ifid_instr}, {32'd0, NOP});
    chk("rst_cnt", {60'd0, stall_count}, 64'd0);

    cyc(0, 0, 0, 64'd0, 0);
    chk("run1_addr", imem_addr, 64'd4);
    chk("run1_ipc", ifid_pc, 64'd0);
    chk("run1_instr", {32'd0, ifid_instr}, 64'h11111111);
    chk("run1_valid", {63'd0, ifid_valid}, 64'd1);
    cyc(0, 0, 0, 64'd0, 0);
    chk("run2_addr", imem_addr, 64'd8);
    chk("run2_instr", {32'd0, ifid_instr}, 64'h22222222);

    cyc(0, 1, 0, 64'd0, 0);
    cyc(0, 1, 0, 64'd0, 0);
    chk("stall_addr", imem_addr, 64'd8);
    chk("stall_ipc", ifid_pc, 64'd4);
    chk("stall_instr", {32'd0, ifid_instr}, 64'h22222222);
    chk("stall_cnt", {60'd0, stall_count}, 64'd2);
    cyc(0, 0, 0, 64'd0, 0);
    chk("release_addr", imem_addr, 64'd12);
    chk("release_instr", {32'd0, ifid_instr}, 64'h33333333);

    cyc(0, 0, 1, 64'h1000, 0);
    chk("redir_addr", imem_addr, 64'h1000);
    chk("redir_valid", {63'd0, ifid_valid}, 64'd0);
    chk("redir_instr", {32'd0, ifid_instr}, {32'd0, NOP});
    cyc(0, 0, 0, 64'd0, 0);
    chk("redir_tgt_ipc", ifid_pc, 64'h1000);
    chk("redir_tgt_valid", {63'd0, ifid_valid}, 64'd1);

    cyc(0, 1, 1, 64'h2000, 0);
    chk("redir_stall_addr", imem_addr, 64'h2000);
    chk("redir_stall_valid", {63'd0, ifid_valid}, 64'd0);
    chk("redir_stall_cnt", {60'd0, stall_count}, 64'd2);

    cyc(0, 0, 1, 64'h20, 0);
    cyc(0, 0, 0, 64'd0, 0);
    cyc(0, 0, 0, 64'd0, 1);
    chk("flush_addr", imem_addr, 64'h28);
    chk("flush_valid", {63'd0, ifid_valid}, 64'd0);
    chk("flush_instr", {32'd0, ifid_instr}, {32'd0, NOP});
    cyc(0, 1, 0, 64'd0, 1);
    chk("flush_stall_addr", imem_addr, 64'h28);
    chk("flush_stall_cnt", {60'd0, stall_count}, 64'd3);

    cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    cyc(0, 0, 0, 64'd0, 0);
    chk("wrap_addr", imem_addr, 64'd0);
    chk("wrap_ipc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    for (int i = 0; i < 20; i++) cyc(0, 1, 0, 64'd0, 0);
    chk("sat_cnt", {60'd0, stall_count}, 64'd15);
    cyc(1, 1, 0, 64'd0, 0);
    chk("rst_stall_addr", imem_addr, 64'd0);
    chk("rst_stall_cnt", {60'd0, stall_count}, 64'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15))
                                       : {$urandom, $urandom};
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
          $urandom_range(0, 99) < 10, rp, $urandom_range(0, 99) < 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_stage.md
Name: fetch_pc_stage

Overview:
- Fetch stage front end: owns the 64-bit program counter and the IF/ID pipeline latch.
- Produces the fetch address for instruction memory and captures the returned instruction plus its PC into IF/ID for decode.
- Accepts branch redirects from later stages, load-use stalls from the hazard unit, and flushes.
- Keeps a saturating count of stall cycles for debug.

Parameters:
- ADDR_W, 64, PC and address width.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'hD503201F, ARM64 NOP encoding inserted on flush/reset.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID (load-use hazard).
- redirect  input  1  taken branch/jump resolved downstream.
- redirect_pc  input  ADDR_W  target PC for redirect.
- flush  input  1  squash IF/ID contents without redirect.
- imem_instr  input  INSTR_W  instruction at imem_addr (combinational memory).
- imem_addr  output  ADDR_W  current PC, equal to pc register.
- ifid_pc  output  ADDR_W  PC of latched instruction.
- ifid_instr  output  INSTR_W  latched instruction.
- ifid_valid  output  1  latched instruction is real (not a bubble).
- stall_count  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (sampled at posedge):
  - pc=RESET_PC, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, stall_count=0.
  - Reset overrides all other inputs, including mid-stall and mid-redirect.
- Priority each edge: reset > redirect > stall > flush > normal.
- Normal (no control asserted):
  - pc <= pc+4, wrapping modulo 2^ADDR_W.
  - ifid_pc <= pc, ifid_instr <= imem_instr, ifid_valid <= 1.
- Redirect:
  - pc <= redirect_pc.
  - IF/ID loaded with bubble: ifid_instr=NOP_INSTR, ifid_valid=0, ifid_pc=0.
  - Redirect overrides a simultaneous stall: the wrong-path fetch is discarded and the target is fetched next cycle.
  - No alignment check; redirect_pc is used as given.
- Stall (no redirect):
  - pc, ifid_pc, ifid_instr and ifid_valid all hold.
  - stall_count increments by 1, saturating at 2^CNT_W-1.
  - A simultaneous flush is ignored; stall wins.
- Flush (no redirect, no stall):
  - pc <= pc+4 (fetch continues).
  - IF/ID loaded with bubble as for redirect.
- Latency:
  - Instruction fetched at PC X appears in ifid_* one cycle after imem_addr=X.
  - After redirect at edge k: imem_addr=target from edge k; target instruction in IF/ID after edge k+1.
- stall_count changes only on stall cycles and reset.
- imem_addr is a direct copy of pc, with no combinational path from any input.
- All outputs are registered.

Test Plan:
- Reset then 3 free-running cycles, imem returns 0x11111111 / 0x22222222 / 0x33333333 -> imem_addr 0, 4, 8, 12. ifid_pc 0, 4, 8 with matching instrs, ifid_valid=1 after first edge.
- Stall held 2 cycles at pc=8 -> pc stays 8, IF/ID holds (pc 4, 0x22222222), stall_count 0->2. Release -> pc=12.
- Redirect to 0x1000 at pc=12 -> next imem_addr=0x1000, ifid_valid=0, ifid_instr=0xD503201F. Following cycle ifid_pc=0x1000, valid=1.
- Redirect and stall both asserted in the same cycle -> redirect wins: pc=redirect_pc, bubble in IF/ID, stall_count unchanged.
- Flush alone at pc=0x20 -> pc=0x24, ifid_valid=0, ifid_instr=NOP. Flush+stall -> holds, flush ignored.
- Wrap and saturation: pc=0xFFFFFFFFFFFFFFFC steps to 0. With CNT_W=4, 20 stall cycles -> stall_count=15. Reset asserted during stall -> pc=RESET_PC, stall_count=0.
